branch_predictor_btb: RTL
=========================

Name: branch_predictor_btb

Overview:
- Parametrised successor to the fixed branch predictor in the MIPS32 5-stage pipeline.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry, a configurable depth and configurable tag width.
- Looked up combinationally with the fetch PC; predicts taken/target for the PC generator.
- Trained by resolved jumps from ID (unconditional) and EX (conditional).

Parameters:
- IDX_W, 4, log2 of entry count (ENTRIES = 2**IDX_W).
- TAG_W, 8, tag bits stored per entry; IDX_W+TAG_W <= 30 required, checked by an elaboration-time error.
- CTR_INIT, 2'b10, counter value loaded on allocation (weakly taken).
- STAT_W, 16, width of statistics counters; used only with BP_STATS_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pc  in  32  fetch byte address; index = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]
- jump_taken_predict  out  1  predict taken for pc
- jump_target_predict  out  30  predicted target word address [31:2]
- upd_valid  in  1  resolved-jump update strobe
- upd_pc  in  32  byte address of the resolved jump instruction
- upd_cond  in  1  1 = conditional (beq/bne), 0 = unconditional (j/jal/jr)
- upd_taken  in  1  resolved direction; ignored when upd_cond=0
- upd_target  in  30  resolved target [31:2]
- inv_all  in  1  invalidate all entries (context switch / self-modifying code)

Behaviour:
- Entry fields: valid, tag[TAG_W], target[30], ctr[2], uncond.
- Lookup is purely combinational from pc and the current table state.
  - hit = valid[idx] && tag[idx] == pc tag.
  - jump_taken_predict = hit && (uncond[idx] || ctr[idx][1]).
  - jump_target_predict = target[idx] when jump_taken_predict=1, else 0.
- Reset (async, rst=1): all valid=0, ctr=2'b01, uncond=0, target=0, tag=0. Both outputs are therefore 0 while rst is high and until the first allocation.
- Updates are applied on the rising clk edge when upd_valid=1, using idx/tag from upd_pc:
  - Unconditional, hit or miss: write valid=1, tag, target=upd_target, uncond=1, ctr=2'b11.
  - Conditional hit, taken: ctr saturating increment (11 stays 11); target overwritten with upd_target; uncond=0.
  - Conditional hit, not-taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Conditional miss, taken: allocate with valid=1, tag, target, uncond=0, ctr=CTR_INIT. Any entry previously at that index is replaced.
  - Conditional miss, not-taken: no write.
- No write-to-read bypass: a lookup in the same cycle as an update to the same index sees the pre-update entry. The new contents are visible from the next cycle.
- inv_all=1 at a clock edge clears every valid bit and leaves other fields untouched. It has priority over a simultaneous upd_valid, which is dropped.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Latency: prediction 0 cycles (combinational); training 1 cycle.
- upd_pc[1:0] and pc[1:0] are ignored.

Optional Feature:
- Macro: BP_STATS_EN
- Defined, the block adds three outputs:
  - stat_lookups [STAT_W] counts every cycle.
  - stat_hits [STAT_W] counts cycles with hit=1.
  - stat_upd_miss [STAT_W] counts upd_valid cycles where the table's prediction for upd_pc disagrees with the resolved outcome (direction, or target when taken).
  - All three saturate at all-ones, reset to 0 on rst, and are unaffected by inv_all.
- Undefined: the ports and logic are absent, and prediction/training behaviour is identical.

Decomposition:
- Package bp_pkg holds:
  - typedef bp_ctr_t (2-bit).
  - Constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Function bp_ctr_next(ctr, taken) for the saturating step.
- One sub-module, bp_sat_ctr (generic STAT_W saturating counter with enable), instantiated three times under BP_STATS_EN.
- The table itself is flat register arrays in the top; no RAM macro.

Test Plan:
- Reset then pc=0x0000_0040 -> jump_taken_predict=0, jump_target_predict=0.
- upd_valid, upd_cond=0, upd_pc=0x40, upd_target=0x100>>2 -> next cycle pc=0x40 gives taken=1, target=0x40; pc=0x440 (same index, different tag) gives taken=0.
- Conditional at 0x80, taken once (ctr=10), not-taken once (01) -> predict 0; then taken x3 -> ctr 11, one not-taken -> 10, still predicts 1. Ten further not-taken updates leave ctr at 00, no underflow.
- Conditional miss not-taken at 0xC0 -> no allocation, lookup 0xC0 still misses. Update to idx 3 in the same cycle as lookup 0x0C -> old value seen that cycle, new value the next.
- inv_all and upd_valid in the same cycle -> all lookups miss next cycle, update dropped. rst pulsed between clk edges -> outputs 0 immediately.
- BP_STATS_EN: 20 cycles with 5 hits and 2 mispredicted updates -> stat_lookups=20, stat_hits=5, stat_upd_miss=2. Forcing STAT_W=4 over 20 cycles -> stat_lookups holds at 15.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and the saturating 2-bit direction-counter step for the branch predictor.
// Pure declarations; no timing or flow control of its own.
package bp_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t SNT = 2'b00;
  localparam bp_ctr_t WNT = 2'b01;
  localparam bp_ctr_t WT  = 2'b10;
  localparam bp_ctr_t ST  = 2'b11;

  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'b01;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Generic W-bit event counter that sticks at all-ones; 1-cycle update latency.
// No backpressure: counts whenever en is high at a clock edge.
module bp_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters: 0-cycle lookup, 1-cycle training, no backpressure.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int      IDX_W    = 4,
  parameter int      TAG_W    = 8,
  parameter bp_ctr_t CTR_INIT = 2'b10,
  parameter int      STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic              jump_taken_predict,
  output logic [29:0]       jump_target_predict,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_cond,
  input  logic              upd_taken,
  input  logic [29:0]       upd_target,
`ifdef BP_STATS_EN
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_upd_miss,
`endif
  input  logic              inv_all
);

  localparam int ENTRIES = 1 << IDX_W;

  if (IDX_W + TAG_W > 30) begin : g_bad_geometry
    $error("branch_predictor_btb: IDX_W + TAG_W must not exceed 30");
  end
  if (STAT_W < 1) begin : g_bad_stat_w
    $error("branch_predictor_btb: STAT_W must be at least 1");
  end

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] uncond_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  bp_ctr_t            ctr_q [ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  // Byte-offset bits and anything above the tag never participate in lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc, upd_pc};

  assign idx   = pc[IDX_W+1:2];
  assign tag   = pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign jump_taken_predict  = hit && (uncond_q[idx] || ctr_q[idx][1]);
  assign jump_target_predict = jump_taken_predict ? tgt_q[idx] : 30'd0;

  // Lookup reads the registered table, so a same-cycle update is only seen next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      uncond_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= WNT;
      end
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (!upd_cond) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        tgt_q[u_idx]    <= upd_target;
        uncond_q[u_idx] <= 1'b1;
        ctr_q[u_idx]    <= ST;
      end else if (u_hit) begin
        ctr_q[u_idx] <= bp_ctr_next(ctr_q[u_idx], upd_taken);
        if (upd_taken) begin
          tgt_q[u_idx]    <= upd_target;
          uncond_q[u_idx] <= 1'b0;
        end
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        tgt_q[u_idx]    <= upd_target;
        uncond_q[u_idx] <= 1'b0;
        ctr_q[u_idx]    <= CTR_INIT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic        u_pred_taken;
  logic        u_actual_taken;
  logic        u_mispredict;

  assign u_pred_taken   = u_hit && (uncond_q[u_idx] || ctr_q[u_idx][1]);
  assign u_actual_taken = upd_cond ? upd_taken : 1'b1;
  // A correct direction still counts as a miss when the taken target was wrong.
  assign u_mispredict   = (u_pred_taken != u_actual_taken) ||
                          (u_actual_taken && (tgt_q[u_idx] != upd_target));

  bp_sat_ctr #(.W(STAT_W)) u_stat_lookups (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (stat_lookups)
  );

  bp_sat_ctr #(.W(STAT_W)) u_stat_hits (
    .clk   (clk),
    .rst   (rst),
    .en    (hit),
    .count (stat_hits)
  );

  bp_sat_ctr #(.W(STAT_W)) u_stat_upd_miss (
    .clk   (clk),
    .rst   (rst),
    .en    (upd_valid && u_mispredict),
    .count (stat_upd_miss)
  );
`endif

endmodule
